// File: rtl/gf571_reduce_seq.sv
// GF(2^571) digit-serial reducer (f = x^571+x^10+x^5+x^2+1): STEPS=570/DIGIT fold cycles accept-to-valid, one op in flight,
// in_ready low from accept until the result is taken; GF571_SQR_EN adds a sqr port that loads the bit-spread of a[570:0].
module gf571_reduce_seq #(
    parameter int DIGIT = 57
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1140:0] a,
`ifdef GF571_SQR_EN
    input  logic          sqr,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [570:0]  c
);

    localparam int STEPS = (DIGIT > 0) ? (570 / DIGIT) : 1;
    localparam logic [9:0] K_LAST = 10'(STEPS - 1);
    localparam logic [1140:0] DMASK = {{(1141 - DIGIT){1'b0}}, {DIGIT{1'b1}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((DIGIT < 1) || (DIGIT > 285) || ((570 % DIGIT) != 0)) begin : g_bad_digit
            $error("gf571_reduce_seq: DIGIT must divide 570 and be <= 285");
        end
    endgenerate

    logic [1:0]    state;
    logic [9:0]    k;
    logic [1140:0] r;
    logic [1140:0] r_fold;
    logic [1140:0] h_ext;
    logic [1140:0] load_val;
    logic [10:0]   p;

    // One fold: the top live digit is cleared and re-injected at x^0, x^2, x^5, x^10 relative to p-571.
    always_comb begin
        p      = 11'(1141 - (int'(k) + 1) * DIGIT);
        h_ext  = (r >> p) & DMASK;
        r_fold = (r & ~(DMASK << p))
               ^ (h_ext << (p - 11'd571))
               ^ (h_ext << (p - 11'd569))
               ^ (h_ext << (p - 11'd566))
               ^ (h_ext << (p - 11'd561));
    end

`ifdef GF571_SQR_EN
    always_comb begin
        load_val = a;
        if (sqr) begin
            load_val = '0;
            for (int i = 0; i < 571; i++) begin
                load_val[2*i] = a[i];
            end
        end
    end
`else
    assign load_val = a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r        <= load_val;
                        k        <= '0;
                        state    <= FOLD;
                        in_ready <= 1'b0;
                    end
                end
                FOLD: begin
                    r <= r_fold;
                    if (k == K_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        k <= k + 10'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign c = r[570:0];

endmodule
